// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants used by the fetch stage.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_DRAIN
  } fetch_state_e;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory req/rsp channel and the decode valid/ready channel.
interface instr_fetch_unit_if;
  import rv32i_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;

  // Fetch-unit side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  // Memory/decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instruction words; the head is read from registered storage.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  // Storage, pointers and occupancy; flush empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch stage: credit-limited sequential fetching, buffering, and redirect with stale-response drop.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                busy,
  instr_fetch_unit_if.master  bus
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CCW = CW + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] deliver_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [ILEN-1:0] head_data;

  logic            credit_ok;
  logic            req_valid;
  logic            issue;
  logic            rsp;
  logic            push;
  logic            pop;
  logic [CW-1:0]   drop_next;
  logic [XLEN-1:0] target_pc;

  // Handshake decode; a redirect suppresses issue, push and pop in its cycle.
  always_comb begin
    rsp       = bus.imem_rsp_valid;
    credit_ok = (CCW'(outstanding) + CCW'(count)) < CCW'(DEPTH);
    req_valid = (state != S_BOOT) && !redirect_valid && credit_ok;
    issue     = req_valid && bus.imem_req_ready;
    push      = rsp && (drop_cnt == '0) && !redirect_valid;
    pop       = (count != '0) && bus.instr_ready && !redirect_valid;
    target_pc = align_pc(redirect_pc);
    drop_next = drop_cnt;
    if (redirect_valid)               drop_next = outstanding - CW'(rsp);
    else if (rsp && drop_cnt != '0)   drop_next = drop_cnt - CW'(1);
  end

  // FSM, PCs and in-flight accounting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      deliver_pc  <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case (state)
        S_BOOT:  state <= S_FETCH;
        default: state <= (drop_next != '0) ? S_DRAIN : S_FETCH;
      endcase
      outstanding <= outstanding + CW'(issue) - CW'(rsp);
      drop_cnt    <= drop_next;
      if (redirect_valid) begin
        fetch_pc   <= target_pc;
        deliver_pc <= target_pc;
      end else begin
        if (issue) fetch_pc   <= fetch_pc + PC_STEP;
        if (pop)   deliver_pc <= deliver_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ILEN)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.imem_rsp_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = (count != '0);
  assign bus.instr_data     = head_data;
  assign bus.instr_pc       = deliver_pc;
  assign busy               = (outstanding != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scripted table, hand sequences for redirect/reset corners, random run vs queue model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] addr; logic stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } bent_t;
  typedef struct {
    logic        ir;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t mq[$];
  infl_t m_infl[$];
  bent_t m_buf[$];
  logic [31:0] m_fetch, m_deliver;
  logic        m_boot;
  int          cyc;
  int          lat_min, lat_max;
  int          n_pass, n_total;
  vec_t        tbl[16];

  logic        s_req_valid, s_instr_valid, s_busy;
  logic [31:0] s_req_addr, s_instr_pc, s_instr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl.delete();
    m_buf.delete();
    m_fetch   = RESET_PC;
    m_deliver = RESET_PC;
    m_boot    = 1'b1;
    cyc       = 0;
  endtask

  // Called at edge+1; asserts reset mid-cycle, checks outputs immediately, then releases at a later edge+1.
  task automatic do_reset();
    reset              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b0;
    bus.imem_req_ready = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
    chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr_data", bus.instr_data, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, RESET_PC);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rst_hold_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
      chk("rst_hold_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    end
    reset = 1'b1;
  endtask

  // One clock cycle: drive inputs, sample and check against the model, advance memory and model, step the clock.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic ir, input logic rr);
    logic        e_rv, rsp_v, pop_ok;
    logic [31:0] tgt;
    infl_t       h;
    rsp_v = (mq.size() != 0) && (mq[0].due <= cyc);
    bus.imem_rsp_valid = rsp_v;
    bus.imem_rsp_data  = rsp_v ? (mq[0].addr ^ K) : $urandom;
    redirect_valid     = rv;
    redirect_pc        = rpc;
    bus.instr_ready    = ir;
    bus.imem_req_ready = rr;
    #1;
    s_req_valid   = bus.imem_req_valid;
    s_req_addr    = bus.imem_req_addr;
    s_instr_valid = bus.instr_valid;
    s_instr_pc    = bus.instr_pc;
    s_instr_data  = bus.instr_data;
    s_busy        = busy;

    e_rv = !m_boot && !rv && ((m_infl.size() + m_buf.size()) < DEPTH);
    chk("m_req_valid", {31'b0, s_req_valid}, {31'b0, e_rv});
    chk("m_req_addr", s_req_addr, m_fetch);
    chk("m_instr_valid", {31'b0, s_instr_valid}, {31'b0, m_buf.size() != 0});
    chk("m_busy", {31'b0, s_busy}, {31'b0, m_infl.size() != 0});
    if (m_buf.size() != 0) begin
      chk("m_instr_pc", s_instr_pc, m_buf[0].pc);
      chk("m_instr_data", s_instr_data, m_buf[0].data);
    end else begin
      chk("m_instr_pc_idle", s_instr_pc, m_deliver);
    end

    // Memory sees the DUT's actual request handshake.
    if (rsp_v) void'(mq.pop_front());
    if (s_req_valid && rr) mq.push_back('{addr: s_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});

    // Reference model.
    pop_ok = (m_buf.size() != 0) && ir;
    if (rv) begin
      if (rsp_v && m_infl.size() != 0) void'(m_infl.pop_front());
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_buf.delete();
      tgt       = rpc & ~32'h3;
      m_fetch   = tgt;
      m_deliver = tgt;
    end else begin
      if (pop_ok) begin
        void'(m_buf.pop_front());
        m_deliver = m_deliver + 32'd4;
      end
      if (rsp_v && m_infl.size() != 0) begin
        h = m_infl.pop_front();
        if (!h.stale) m_buf.push_back('{pc: h.addr, data: h.addr ^ K});
      end
      if (e_rv && rr) begin
        m_infl.push_back('{addr: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
    m_boot = 1'b0;

    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got;
    logic [31:0] rpc;
    n_pass = 0; n_total = 0;
    lat_min = 1; lat_max = 1;

    // Reset/stall scenario: instr_ready low for 10 cycles, 1-cycle memory, then release.
    tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    tbl[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[7]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[8]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[9]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[10] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[11] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    tbl[12] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[13] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[14] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[15] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 32'h0, tbl[i].ir, 1'b1);
      chk("tbl_req_valid", {31'b0, s_req_valid}, {31'b0, tbl[i].exp_rv});
      chk("tbl_req_addr", s_req_addr, tbl[i].exp_addr);
      chk("tbl_instr_valid", {31'b0, s_instr_valid}, {31'b0, tbl[i].exp_iv});
      chk("tbl_instr_pc", s_instr_pc, tbl[i].exp_pc);
      if (tbl[i].exp_iv) chk("tbl_instr_data", s_instr_data, tbl[i].exp_pc ^ K);
    end

    // Streaming: one instruction per cycle after fill.
    do_reset();
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (s_instr_valid) begin got = 1'b1; break; end
    end
    chk("t2_first_valid", {31'b0, got}, 32'd1);
    chk("t2_first_pc", s_instr_pc, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      chk("t2_valid", {31'b0, s_instr_valid}, 32'd1);
      chk("t2_pc", s_instr_pc, 32'(4 * k));
      chk("t2_data", s_instr_data, 32'(4 * k) ^ K);
    end

    // 3-cycle memory, redirect with 3 in flight (one responding in the redirect cycle).
    lat_min = 3; lat_max = 3;
    do_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t4_boot_no_req", {31'b0, s_req_valid}, 32'd0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h100, 1'b0, 1'b1);
    chk("t4_busy_at_redirect", {31'b0, s_busy}, 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t4_req_after_redirect", {31'b0, s_req_valid}, 32'd1);
    chk("t4_req_addr", s_req_addr, 32'h100);
    chk("t4_busy_draining", {31'b0, s_busy}, 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t4_no_stale", {31'b0, s_instr_valid}, 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t4_busy_drained", {31'b0, s_busy}, 32'd0);
    chk("t4_req_addr2", s_req_addr, 32'h100);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      if (s_instr_valid) begin got = 1'b1; break; end
    end
    chk("t4_wait_valid", {31'b0, got}, 32'd1);
    chk("t4_pc", s_instr_pc, 32'h100);
    chk("t4_data", s_instr_data, 32'h100 ^ K);

    // Redirect to an unaligned PC alongside a response and a ready decode.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_0102, 1'b1, 1'b1);
    chk("t5_head_before", s_instr_pc, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t5_valid_flushed", {31'b0, s_instr_valid}, 32'd0);
    chk("t5_req_addr", s_req_addr, 32'h100);
    chk("t5_pc", s_instr_pc, 32'h100);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      if (s_instr_valid) begin got = 1'b1; break; end
    end
    chk("t5_wait_valid", {31'b0, got}, 32'd1);
    chk("t5_new_pc", s_instr_pc, 32'h100);
    chk("t5_new_data", s_instr_data, 32'h100 ^ K);

    // Reset in the middle of traffic: 2 outstanding, 2 buffered.
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t6_pre_busy", {31'b0, busy}, 32'd1);
    chk("t6_pre_valid", {31'b0, bus.instr_valid}, 32'd1);
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_boot_no_req", {31'b0, s_req_valid}, 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_restart_addr", s_req_addr, RESET_PC);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (s_instr_valid) begin got = 1'b1; break; end
    end
    chk("t6_wait_valid", {31'b0, got}, 32'd1);
    chk("t6_pc", s_instr_pc, RESET_PC);
    chk("t6_data", s_instr_data, RESET_PC ^ K);

    // Random traffic against the queue model.
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(999) == 0) do_reset();
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle($urandom_range(99) < 4, rpc, $urandom_range(99) < 70, $urandom_range(99) < 80);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
